mul_error_sweeper: RTL and testbench

MUL_ERROR_SWEEPER -- requirements
Module: mul_error_sweeper

---
 rtl/mul_error_sweeper.sv | 114 +++++++++++
 tb/tb_mul_error_sweeper.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mul_error_sweeper.sv
// Exhaustive error sweeper: walks every WIDTH x WIDTH operand pair and scores the multiplier's response.
// Latency WIDTH+1 cycles per pair; no backpressure, and start is ignored until the sweep returns to idle.
module mul_error_sweeper #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   mul_in1,
   output logic [WIDTH-1:0]   mul_in2,
   input  logic [2*WIDTH-1:0] mul_out,
   input  logic               mul_overflow,
   output logic [2*WIDTH:0]   err_count,
   output logic [2*WIDTH-1:0] max_err,
   output logic [4*WIDTH-1:0] sum_err,
   output logic [2*WIDTH:0]   ovf_count
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int PW = 2 * WIDTH;

   typedef enum logic [1:0] {IDLE, REF, SAMPLE, DONE} state_t;
   state_t state, state_nxt;

   logic [CW-1:0] bit_idx;
   logic [PW-1:0] exact;
   logic [PW-1:0] abs_err;
   logic          last_pair;
   logic          ref_last;

   assign last_pair = (&mul_in1) & (&mul_in2);
   assign ref_last  = (bit_idx == CW'(WIDTH - 1));
   // Larger value is always the minuend, so the error never wraps.
   assign abs_err   = (exact >= mul_out) ? (exact - mul_out) : (mul_out - exact);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = REF;
         REF:     if (ref_last) state_nxt = SAMPLE;
         SAMPLE:  state_nxt = last_pair ? DONE : REF;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         REF, SAMPLE: busy = 1'b1;
         DONE:        done = 1'b1;
         default:     ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mul_in1   <= '0;
         mul_in2   <= '0;
         err_count <= '0;
         max_err   <= '0;
         sum_err   <= '0;
         ovf_count <= '0;
         exact     <= '0;
         bit_idx   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  mul_in1   <= '0;
                  mul_in2   <= '0;
                  err_count <= '0;
                  max_err   <= '0;
                  sum_err   <= '0;
                  ovf_count <= '0;
                  exact     <= '0;
                  bit_idx   <= '0;
               end
            end
            REF: begin
               // Shift-add: one multiplier bit of mul_in1 per cycle.
               if (mul_in1[bit_idx]) begin
                  exact <= exact + ({{WIDTH{1'b0}}, mul_in2} << bit_idx);
               end
               bit_idx <= bit_idx + CW'(1);
            end
            SAMPLE: begin
               if (abs_err != '0) err_count <= err_count + (PW + 1)'(1);
               sum_err <= sum_err + (4 * WIDTH)'(abs_err);
               if (abs_err > max_err) max_err <= abs_err;
               if (mul_overflow) ovf_count <= ovf_count + (PW + 1)'(1);
               exact   <= '0;
               bit_idx <= '0;
               if (!last_pair) begin
                  mul_in2 <= mul_in2 + WIDTH'(1);
                  if (&mul_in2) mul_in1 <= mul_in1 + WIDTH'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_error_sweeper.sv
// Bench for mul_error_sweeper: behavioural multiplier responses, a cycle-level sweep model and literal results.
`timescale 1ns/1ps
module tb_mul_error_sweeper;
   localparam int W     = 4;
   localparam int NOPS  = 1 << W;
   localparam int PAIRS = NOPS * NOPS;
   localparam int SWEEP = PAIRS * (W + 1);

   logic           clk   = 1'b0;
   logic           rst_n = 1'b1;
   logic           start = 1'b0;
   logic           busy, done;
   logic [W-1:0]   mul_in1, mul_in2;
   logic [2*W-1:0] mul_out;
   logic           mul_overflow;
   logic [2*W:0]   err_count, ovf_count;
   logic [2*W-1:0] max_err;
   logic [4*W-1:0] sum_err;
   int             mode   = 0;
   int             checks = 0;
   int             errors = 0;

   always #5 clk = ~clk;

   mul_error_sweeper #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .mul_in1(mul_in1), .mul_in2(mul_in2), .mul_out(mul_out), .mul_overflow(mul_overflow),
      .err_count(err_count), .max_err(max_err), .sum_err(sum_err), .ovf_count(ovf_count)
   );

   // Multiplier under test: 0 exact, 1 exact+1 except 15x15, 2 bit0 stuck at 0, 3 overflow always set
   function automatic int resp(input int a, input int b, input int m);
      int p;
      p = a * b;
      case (m)
         1:       return (a == NOPS - 1 && b == NOPS - 1) ? p : p + 1;
         2:       return p & ~1;
         default: return p;
      endcase
   endfunction

   assign mul_out      = (2*W)'(resp(int'(mul_in1), int'(mul_in2), mode));
   assign mul_overflow = (mode == 3);

   // Sweep model: phase 0 idle, 1 running (m_k cycles since accept), 2 done
   int m_phase = 0, m_k = 0, m_in1 = 0, m_in2 = 0;
   int m_err = 0, m_max = 0, m_sum = 0, m_ovf = 0;
   int m_p, m_a, m_b, m_e;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase = 0; m_k = 0; m_in1 = 0; m_in2 = 0;
         m_err = 0; m_max = 0; m_sum = 0; m_ovf = 0;
      end else begin
         case (m_phase)
            0: if (start) begin
               m_phase = 1; m_k = 0; m_in1 = 0; m_in2 = 0;
               m_err = 0; m_max = 0; m_sum = 0; m_ovf = 0;
            end
            1: begin
               m_k++;
               if (m_k % (W + 1) == 0) begin
                  m_p = m_k / (W + 1) - 1;
                  m_a = m_p / NOPS;
                  m_b = m_p % NOPS;
                  m_e = resp(m_a, m_b, mode) - m_a * m_b;
                  if (m_e < 0) m_e = -m_e;
                  if (m_e != 0) m_err++;
                  m_sum += m_e;
                  if (m_e > m_max) m_max = m_e;
                  if (mode == 3) m_ovf++;
                  if (m_k == SWEEP) m_phase = 2;
                  else begin
                     m_in1 = (m_p + 1) / NOPS;
                     m_in2 = (m_p + 1) % NOPS;
                  end
               end
            end
            default: m_phase = 0;
         endcase
      end
   end

   task automatic cycle_compare();
      checks++;
      if (busy !== (m_phase == 1) || done !== (m_phase == 2) ||
          mul_in1 !== W'(m_in1) || mul_in2 !== W'(m_in2) ||
          err_count !== (2*W+1)'(m_err) || max_err !== (2*W)'(m_max) ||
          sum_err !== (4*W)'(m_sum) || ovf_count !== (2*W+1)'(m_ovf)) begin
         errors++;
         $display("FAIL cycle t=%0t got busy=%b done=%b in1=%0d in2=%0d err=%0d max=%0d sum=%0d ovf=%0d want busy=%0b done=%0b in1=%0d in2=%0d err=%0d max=%0d sum=%0d ovf=%0d",
                  $time, busy, done, mul_in1, mul_in2, err_count, max_err, sum_err, ovf_count,
                  m_phase == 1, m_phase == 2, m_in1, m_in2, m_err, m_max, m_sum, m_ovf);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cycle_compare();
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_zero(input string name);
      check(name, ({busy, done, mul_in1, mul_in2, err_count, max_err, sum_err, ovf_count} === '0) ? 0 : 1, 0);
   endtask

   task automatic run_sweep(input int m, input int restart_at, input int reset_at,
                            input int e_err, input int e_max, input int e_sum, input int e_ovf);
      int busy_cyc = 0;
      int done_cnt = 0;
      int post     = 0;
      bit finished = 1'b0;
      bit aborted  = 1'b0;
      mode  = m;
      start = 1'b1;
      for (int c = 0; c < SWEEP + 20 && !finished; c++) begin
         tick();
         start = 1'b0;
         if (busy === 1'b1) busy_cyc++;
         if (done === 1'b1) done_cnt++;
         if (restart_at > 0 && busy_cyc == restart_at && busy === 1'b1) start = 1'b1;
         if (reset_at > 0 && busy_cyc == reset_at) begin
            #1 rst_n = 1'b0;
            #1 check_zero("reset_mid_sweep_outputs");
            tick();
            tick();
            check("reset_mid_sweep_done_pulses", done_cnt, 0);
            #1 rst_n = 1'b1;
            tick();
            check("done_after_mid_reset_release", int'(done), 0);
            aborted  = 1'b1;
            finished = 1'b1;
         end else if (done_cnt > 0) begin
            post++;
            if (post == 3) finished = 1'b1;
         end
      end
      if (aborted) return;
      check("sweep_finished", int'(finished), 1);
      check("busy_cycles", busy_cyc, SWEEP);
      check("done_pulses", done_cnt, 1);
      check("err_count", int'(err_count), e_err);
      check("max_err", int'(max_err), e_max);
      check("sum_err", int'(sum_err), e_sum);
      check("ovf_count", int'(ovf_count), e_ovf);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #1 check_zero("reset_async");
      tick();
      tick();
      #1 rst_n = 1'b1;
      tick();
      check("done_after_release", int'(done), 0);
      tick();

      run_sweep(0, -1, -1,   0, 0,   0,   0);
      run_sweep(1, -1, -1, 255, 1, 255,   0);
      run_sweep(2, -1, -1,  64, 1,  64,   0);
      run_sweep(3, -1, -1,   0, 0,   0, 256);
      run_sweep(0, 100, -1,  0, 0,   0,   0);
      run_sweep(1, -1, 500,  0, 0,   0,   0);
      run_sweep(1, -1, -1, 255, 1, 255,   0);

      repeat (5) tick();
      check("hold_err_count", int'(err_count), 255);
      check("hold_operands", int'({mul_in1, mul_in2}), 255);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
